otter_mem_arbiter: RTL and testbench

- Shares one single-ported memory bus between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined OTTER.
- Sequences each access with a request/acknowledge handshake and captures the result.
- Generates a global pipeline stall so the IF/ID, ID/EX, EX/MEM and MEM/WB registers hold while an access is outstanding.
- Sits between the EX/MEM register outputs, the PC/fetch logic and the memory module.

---
 rtl/otter_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_arbiter.sv
// Shares one single-ported memory bus between OTTER instruction fetch and load/store.
// Define OTTER_MEM_ARB_RR_EN for round-robin tie-breaking in IDLE (default: MEM beats IF).
module otter_mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_DATA,
    output logic        IF_DONE,
    input  logic        MEM_READ_2,
    input  logic        MEM_WRITE,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WDATA,
    input  logic [1:0]  SIZE,
    input  logic        SIGN,
    output logic [31:0] MEM_DATA,
    output logic        MEM_DONE,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    output logic [1:0]  BUS_SIZE,
    output logic        BUS_SIGN,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA,
    output logic        STALL,
    output logic        ERR
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, RESP} state_t;

    state_t          state_q, state_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [1:0]      bus_size_q, bus_size_d;
    logic            bus_sign_q, bus_sign_d;
    logic [31:0]     if_data_q, if_data_d;
    logic [31:0]     mem_data_q, mem_data_d;
    logic            if_done_q, if_done_d;
    logic            mem_done_q, mem_done_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            served_mem_q, served_mem_d;
`ifdef OTTER_MEM_ARB_RR_EN
    logic            last_mem_q, last_mem_d;
`endif

    logic mem_req;
    logic grant_if;
    logic grant_mem;
    logic timeout_hit;
    logic done_now;
    logic [31:0] done_data;

    assign mem_req = MEM_READ_2 | MEM_WRITE;
    // The counter holds the number of wait cycles already spent, so the TIMEOUT-th cycle aborts.
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_size_d   = bus_size_q;
        bus_sign_d   = bus_sign_q;
        if_data_d    = if_data_q;
        mem_data_d   = mem_data_q;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        err_d        = err_q;
        cnt_d        = cnt_q;
        served_mem_d = served_mem_q;
        grant_if     = 1'b0;
        grant_mem    = 1'b0;
        done_now     = 1'b0;
        done_data    = BUS_RDATA;
`ifdef OTTER_MEM_ARB_RR_EN
        last_mem_d   = last_mem_q;
`endif

        case (state_q)
            IDLE: begin
                if (mem_req && IF_REQ) begin
`ifdef OTTER_MEM_ARB_RR_EN
                    grant_if  = last_mem_q;
                    grant_mem = ~last_mem_q;
`else
                    grant_mem = 1'b1;
`endif
                end else if (mem_req) begin
                    grant_mem = 1'b1;
                end else if (IF_REQ) begin
                    grant_if = 1'b1;
                end
`ifdef OTTER_MEM_ARB_RR_EN
                if (grant_if || grant_mem) begin
                    last_mem_d = grant_mem;
                end
`endif
            end
            GNT_IF, GNT_MEM: begin
                cnt_d = cnt_q + CW'(1);
                if (BUS_ACK) begin
                    done_now = 1'b1;
                end else if (timeout_hit) begin
                    done_now  = 1'b1;
                    done_data = ERR_DATA;
                    err_d     = 1'b1;
                end
                if (done_now) begin
                    bus_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == GNT_IF) begin
                        if_data_d = done_data;
                        if_done_d = 1'b1;
                    end else begin
                        if (!bus_we_q) begin
                            mem_data_d = done_data;
                        end
                        mem_done_d = 1'b1;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
                // The requester just served still holds its request this cycle; only hand over to the other.
                if (served_mem_q && IF_REQ) begin
                    grant_if = 1'b1;
                end else if (!served_mem_q && mem_req) begin
                    grant_mem = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_mem) begin
            state_d      = GNT_MEM;
            bus_req_d    = 1'b1;
            bus_we_d     = MEM_WRITE;
            bus_addr_d   = MEM_ADDR;
            bus_wdata_d  = MEM_WDATA;
            bus_size_d   = SIZE;
            bus_sign_d   = SIGN;
            served_mem_d = 1'b1;
            cnt_d        = '0;
        end else if (grant_if) begin
            state_d      = GNT_IF;
            bus_req_d    = 1'b1;
            bus_we_d     = 1'b0;
            bus_addr_d   = IF_ADDR;
            bus_wdata_d  = '0;
            bus_size_d   = 2'b10;
            bus_sign_d   = 1'b0;
            served_mem_d = 1'b0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_size_q   <= '0;
            bus_sign_q   <= 1'b0;
            if_data_q    <= '0;
            mem_data_q   <= '0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            served_mem_q <= 1'b0;
`ifdef OTTER_MEM_ARB_RR_EN
            last_mem_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_size_q   <= bus_size_d;
            bus_sign_q   <= bus_sign_d;
            if_data_q    <= if_data_d;
            mem_data_q   <= mem_data_d;
            if_done_q    <= if_done_d;
            mem_done_q   <= mem_done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            served_mem_q <= served_mem_d;
`ifdef OTTER_MEM_ARB_RR_EN
            last_mem_q   <= last_mem_d;
`endif
        end
    end

    assign BUS_REQ   = bus_req_q;
    assign BUS_WE    = bus_we_q;
    assign BUS_ADDR  = bus_addr_q;
    assign BUS_WDATA = bus_wdata_q;
    assign BUS_SIZE  = bus_size_q;
    assign BUS_SIGN  = bus_sign_q;
    assign IF_DATA   = if_data_q;
    assign IF_DONE   = if_done_q;
    assign MEM_DATA  = mem_data_q;
    assign MEM_DONE  = mem_done_q;
    assign ERR       = err_q;
    assign STALL     = (IF_REQ & ~if_done_q) | (mem_req & ~mem_done_q);
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter: requesters push expected results, a monitor pops on DONE,
// and a bus responder model acknowledges with data derived from the address.
module tb_otter_mem_arbiter;
    localparam int unsigned TO = 4;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        CLK, RST;
    logic        IF_REQ;
    logic [31:0] IF_ADDR, IF_DATA;
    logic        IF_DONE;
    logic        MEM_READ_2, MEM_WRITE;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_DATA;
    logic [1:0]  SIZE;
    logic        SIGN;
    logic        MEM_DONE;
    logic        BUS_REQ, BUS_WE;
    logic [31:0] BUS_ADDR, BUS_WDATA;
    logic [1:0]  BUS_SIZE;
    logic        BUS_SIGN;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;
    logic        STALL, ERR;

    otter_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_DATA(IF_DATA), .IF_DONE(IF_DONE),
        .MEM_READ_2(MEM_READ_2), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .SIZE(SIZE), .SIGN(SIGN),
        .MEM_DATA(MEM_DATA), .MEM_DONE(MEM_DONE),
        .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
        .BUS_SIZE(BUS_SIZE), .BUS_SIGN(BUS_SIGN), .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA),
        .STALL(STALL), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    // Scoreboard queues and reference state
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];
    int          done_order[$];
    logic [31:0] model_last = '0;

    // Responder control
    bit          resp_en = 1'b1;
    int          fixed_lat = 0;
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;
    bit          inject_ack = 1'b0;
    int          last_run = 0;

    // Fields of the currently outstanding request from each side
    logic [31:0] if_cur_addr = '0;
    logic        mem_cur_we = 1'b0;
    logic [31:0] mem_cur_addr = '0, mem_cur_wdata = '0;
    logic [1:0]  mem_cur_size = '0;
    logic        mem_cur_sign = 1'b0;

    // Bus responder: IF addresses have bit 13 clear, MEM addresses have it set.
    initial begin
        int req_cycles;
        int cur_lat;
        req_cycles = 0;
        cur_lat    = 1;
        BUS_ACK    = 1'b0;
        BUS_RDATA  = '0;
        forever begin
            @(negedge CLK);
            BUS_ACK   = 1'b0;
            BUS_RDATA = $urandom();
            if (inject_ack) begin
                BUS_ACK = 1'b1;
            end else if (BUS_REQ) begin
                req_cycles++;
                if (req_cycles == 1) cur_lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
                if (BUS_ADDR[13]) begin
                    check("bus_mem_addr", BUS_ADDR, mem_cur_addr);
                    check("bus_mem_ctl", {BUS_WE, BUS_SIZE, BUS_SIGN},
                          {mem_cur_we, mem_cur_size, mem_cur_sign});
                    if (mem_cur_we) check("bus_mem_wdata", BUS_WDATA, mem_cur_wdata);
                end else begin
                    check("bus_if_addr", BUS_ADDR, if_cur_addr);
                    check("bus_if_we", BUS_WE, 1'b0);
                end
                if (resp_en && req_cycles == cur_lat) begin
                    BUS_ACK    = 1'b1;
                    BUS_RDATA  = force_en ? force_val : rd_val(BUS_ADDR);
                    last_run   = req_cycles;
                    req_cycles = 0;
                end
            end else begin
                if (req_cycles != 0) last_run = req_cycles;
                req_cycles = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a DONE pulse is presented.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge CLK);
            if (IF_DONE) begin
                done_order.push_back(0);
                if (exp_if_q.size() == 0) check("if_done_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_if_q.pop_front();
                    check("if_data", IF_DATA, e);
                end
            end
            if (MEM_DONE) begin
                done_order.push_back(1);
                if (exp_mem_q.size() == 0) check("mem_done_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_mem_q.pop_front();
                    check("mem_data", MEM_DATA, e);
                end
            end
        end
    end

    task automatic if_access(input logic [31:0] addr, output int lat,
                             output logic st_mid, output logic st_done);
        logic [31:0] e;
        bit got;
        e = force_en ? force_val : (resp_en ? rd_val(addr) : ERRD);
        exp_if_q.push_back(e);
        if_cur_addr = addr;
        IF_ADDR = addr;
        IF_REQ  = 1'b1;
        lat = 0; got = 1'b0; st_mid = 1'b0; st_done = 1'b1;
        while (!got && lat < 60) begin
            @(negedge CLK);
            lat++;
            if (lat == 1) st_mid = STALL;
            if (IF_DONE) begin
                got = 1'b1;
                st_done = STALL;
            end
        end
        check("if_done_seen", 32'(got), 32'd1);
        IF_REQ  = 1'b0;
        IF_ADDR = $urandom();
    endtask

    task automatic mem_access(input logic rd, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] sz, input logic sg,
                              output int lat);
        logic [31:0] e;
        bit got;
        if (we) e = model_last;
        else begin
            e = force_en ? force_val : (resp_en ? rd_val(addr) : ERRD);
            model_last = e;
        end
        exp_mem_q.push_back(e);
        mem_cur_we = we; mem_cur_addr = addr; mem_cur_wdata = wdata;
        mem_cur_size = sz; mem_cur_sign = sg;
        MEM_READ_2 = rd; MEM_WRITE = we; MEM_ADDR = addr; MEM_WDATA = wdata;
        SIZE = sz; SIGN = sg;
        lat = 0; got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge CLK);
            lat++;
            if (MEM_DONE) got = 1'b1;
        end
        check("mem_done_seen", 32'(got), 32'd1);
        MEM_READ_2 = 1'b0; MEM_WRITE = 1'b0;
        MEM_ADDR = $urandom(); MEM_WDATA = $urandom();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb;
        logic sm, sd;
        RST = 1'b1; IF_REQ = 1'b0; IF_ADDR = '0;
        MEM_READ_2 = 1'b0; MEM_WRITE = 1'b0; MEM_ADDR = '0; MEM_WDATA = '0;
        SIZE = '0; SIGN = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_bus_req", BUS_REQ, 1'b0);
        check("rst_bus_fields", BUS_ADDR | BUS_WDATA | {28'd0, BUS_WE, BUS_SIZE, BUS_SIGN}, 32'd0);
        check("rst_if_data", IF_DATA, 32'd0);
        check("rst_mem_data", MEM_DATA, 32'd0);
        check("rst_done_err_stall", {IF_DONE, MEM_DONE, ERR, STALL}, 4'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Single fetch, ACK on the third BUS_REQ cycle
        fixed_lat = 3; force_en = 1'b1; force_val = 32'h00500093;
        if_access(32'h100, la, sm, sd);
        check("if_latency", la, 4);
        check("if_stall_wait", sm, 1'b1);
        check("if_stall_done", sd, 1'b0);
        @(negedge CLK);
        check("if_done_one_cycle", IF_DONE, 1'b0);
        force_en = 1'b0;

        // Simultaneous requests: MEM first, handover to IF with no IDLE cycle
        fixed_lat = 2;
        done_order.delete();
        fork
            if_access(32'h104, la, sm, sd);
            mem_access(1'b1, 1'b0, 32'h2000, 32'h0, 2'b10, 1'b0, lb);
        join
        check("pair1_first", done_order.size() > 0 ? done_order[0] : 9, 1);
        check("pair1_mem_lat", lb, 3);
        check("pair1_if_lat", la, 6);
        @(negedge CLK);
        done_order.delete();
        fork
            if_access(32'h108, la, sm, sd);
            mem_access(1'b1, 1'b0, 32'h2040, 32'h0, 2'b00, 1'b1, lb);
        join
`ifdef OTTER_MEM_ARB_RR_EN
        check("pair2_first", done_order.size() > 0 ? done_order[0] : 9, 0);
        check("pair2_lat", {16'(la), 16'(lb)}, {16'd3, 16'd6});
`else
        check("pair2_first", done_order.size() > 0 ? done_order[0] : 9, 1);
        check("pair2_lat", {16'(la), 16'(lb)}, {16'd6, 16'd3});
`endif
        @(negedge CLK);

        // Store: MEM_DATA must keep the last load value
        fixed_lat = 3;
        mem_access(1'b0, 1'b1, 32'h3004, 32'hCAFEF00D, 2'b01, 1'b1, lb);
        check("store_lat", lb, 4);
        @(negedge CLK);
        check("store_done_one_cycle", MEM_DONE, 1'b0);

        // ACK arrives on the same cycle the timeout would fire
        fixed_lat = TO; force_en = 1'b1; force_val = 32'h12345678;
        mem_access(1'b1, 1'b0, 32'h2010, 32'h0, 2'b10, 1'b0, lb);
        force_en = 1'b0;
        check("collide_lat", lb, TO + 1);
        @(negedge CLK);
        check("collide_err", ERR, 1'b0);

        // No ACK at all: timeout after TO request cycles
        resp_en = 1'b0;
        mem_access(1'b1, 1'b0, 32'h2020, 32'h0, 2'b10, 1'b0, lb);
        check("timeout_lat", lb, TO + 1);
        @(negedge CLK);
        check("timeout_req_cycles", last_run, TO);
        check("timeout_err", ERR, 1'b1);
        resp_en = 1'b1; fixed_lat = 1;
        if_access(32'h200, la, sm, sd);
        check("err_sticky", ERR, 1'b1);
        @(negedge CLK);

        // Reset in the middle of a load, then a stray ACK
        resp_en = 1'b0;
        mem_cur_we = 1'b0; mem_cur_addr = 32'h2200; mem_cur_size = 2'b10; mem_cur_sign = 1'b0;
        MEM_READ_2 = 1'b1; MEM_ADDR = 32'h2200; SIZE = 2'b10; SIGN = 1'b0;
        repeat (2) @(negedge CLK);
        check("abort_req_before", BUS_REQ, 1'b1);
        RST = 1'b1; MEM_READ_2 = 1'b0;
        @(negedge CLK);
        check("abort_req_after", BUS_REQ, 1'b0);
        check("abort_flags", {MEM_DONE, ERR}, 2'b00);
        check("abort_mem_data", MEM_DATA, 32'd0);
        RST = 1'b0; model_last = '0;
        inject_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 1) inject_ack = 1'b0;
            check("late_ack_quiet", {BUS_REQ, MEM_DONE, IF_DONE}, 3'b000);
        end
        resp_en = 1'b1; fixed_lat = 1;
        mem_access(1'b1, 1'b0, 32'h2300, 32'h0, 2'b10, 1'b0, lb);
        check("post_abort_lat", lb, 2);
        @(negedge CLK);

        // Randomized concurrent traffic
        fixed_lat = 0;
        fork
            begin
                int l; logic a, b;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge CLK);
                    if_access(32'($urandom_range(0, 32'h7FF)) << 2, l, a, b);
                end
            end
            begin
                int l; int kind;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge CLK);
                    kind = $urandom_range(0, 2);
                    mem_access(kind != 1, kind != 0, 32'h2000 | ($urandom() & 32'h1FFC),
                               $urandom(), 2'($urandom_range(0, 2)), 1'($urandom()), l);
                end
            end
        join
        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 32'(exp_if_q.size() + exp_mem_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
